// File: rtl/avalon_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : avalon_write_buffer
// Description : Posted-write buffer between a cache Avalon master and memory.
//               Writes queue in a DEPTH-entry FIFO and drain in the
//               background; reads take bus priority and are either forwarded
//               from a full-word queued entry or held until the hazard drains.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] c_address,
  input  logic        c_write,
  input  logic        c_read,
  input  logic [31:0] c_writedata,
  input  logic [3:0]  c_byteenable,
  output logic        c_waitrequest,
  output logic [31:0] c_readdata,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_RESP = 3'd3,
    S_FWD  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [29:0]      fifo_addr_q [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [3:0]       fifo_be_q   [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;

  logic             write_q, read_q;
  logic [31:0]      address_q, writedata_q, c_readdata_q;
  logic [3:0]       byteenable_q;

  logic             hit, fwd, pop, push, full;
  logic [PTR_W-1:0] hit_idx;

  // Hazard lookup: scan valid entries oldest to youngest so the youngest match wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(i)} < count_q) &&
          (fifo_addr_q[PTR_W'(head_q + PTR_W'(i))] == c_address[31:2])) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(head_q + PTR_W'(i));
      end
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign fwd  = hit && (fifo_be_q[hit_idx] == 4'hF);
  assign pop  = (state_q == S_WR) && !waitrequest;
  assign full = (count_q == CNT_FULL) && !pop;
  assign push = c_write && !full;

  assign c_waitrequest = c_write ? full : !((state_q == S_RESP) || (state_q == S_FWD));
  assign empty         = (count_q == '0) && (state_q != S_WR);

  assign write      = write_q;
  assign read       = read_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign c_readdata = c_readdata_q;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
        fifo_be_q[i]   <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifo_addr_q[tail_q] <= c_address[31:2];
        fifo_data_q[tail_q] <= c_writedata;
        fifo_be_q[tail_q]   <= c_byteenable;
        tail_q              <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PTR_W+1)'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: reads win over draining, but a started bus write always finishes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (c_read && fwd) begin
          state_d = S_FWD;
        end else if (c_read && !hit) begin
          state_d = S_RD;
        end else if (count_q != '0) begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (!waitrequest) state_d = S_IDLE;
      end
      S_RD: begin
        if (!waitrequest) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      S_FWD:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered bus outputs and upstream read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      c_readdata_q <= '0;
    end else begin
      write_q <= (state_d == S_WR);
      read_q  <= (state_d == S_RD);
      case (state_d)
        S_WR: begin
          address_q    <= {fifo_addr_q[head_q], 2'b00};
          writedata_q  <= fifo_data_q[head_q];
          byteenable_q <= fifo_be_q[head_q];
        end
        S_RD: begin
          address_q    <= c_address;
          writedata_q  <= '0;
          byteenable_q <= 4'hF;
        end
        default: begin
          address_q    <= '0;
          writedata_q  <= '0;
          byteenable_q <= '0;
        end
      endcase
      if ((state_q == S_RD) && !waitrequest) begin
        c_readdata_q <= readdata;
      end else if ((state_q == S_IDLE) && (state_d == S_FWD)) begin
        c_readdata_q <= fifo_data_q[hit_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_write_buffer
// Description : Self-checking bench for avalon_write_buffer with a memory
//               slave model and a word-level golden memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_write_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] c_address = '0;
  logic        c_write = 1'b0;
  logic        c_read = 1'b0;
  logic [31:0] c_writedata = '0;
  logic [3:0]  c_byteenable = '0;
  logic        c_waitrequest;
  logic [31:0] c_readdata;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = '0;
  logic        empty;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] mem [logic [29:0]];
  int          wr_mode = 0;
  int          bus_wr_cnt = 0;
  int          bus_rd_cnt = 0;
  int          rd_pending = 0;

  avalon_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .c_address(c_address), .c_write(c_write), .c_read(c_read),
    .c_writedata(c_writedata), .c_byteenable(c_byteenable),
    .c_waitrequest(c_waitrequest), .c_readdata(c_readdata),
    .address(address), .write(write), .read(read),
    .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(logic [29:0] k);
    return {2'b00, k} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(logic [29:0] k);
    return mem.exists(k) ? mem[k] : init_word(k);
  endfunction

  // Value a read must return: memory contents with every accepted write applied
  function automatic logic [31:0] golden_read(logic [31:0] a);
    logic [31:0] v;
    v = mem_rd(a[31:2]);
    foreach (exp_q[i]) if (exp_q[i].a == a[31:2]) v = merge(v, exp_q[i].d, exp_q[i].be);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory slave: picks waitrequest each cycle and retires completed transfers
  always @(negedge clk) begin : slave
    ent_t e;
    if (wr_mode == 0)      waitrequest = 1'b0;
    else if (wr_mode == 1) waitrequest = 1'b1;
    else                   waitrequest = ($urandom_range(0, 2) == 0);
    readdata = read ? mem_rd(address[31:2]) : $urandom;
    if (reset && (write || read)) chk("bus_strobe_excl", 32'(write && read), 32'd0);
    if (reset && write && !waitrequest) begin
      chk("bus_wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("bus_wr_addr", address, {e.a, 2'b00});
        chk("bus_wr_data", writedata, e.d);
        chk("bus_wr_be", 32'(byteenable), 32'(e.be));
      end
      mem[address[31:2]] = merge(mem_rd(address[31:2]), writedata, byteenable);
      bus_wr_cnt++;
    end
    if (reset && read && !waitrequest) begin
      bus_rd_cnt++;
      rd_pending = exp_q.size();
    end
  end

  // Upstream write; entered and left just after a rising edge
  task automatic up_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int stalls, output int wrc);
    bit   done;
    ent_t e;
    c_write = 1'b1; c_address = a; c_writedata = d; c_byteenable = be;
    stalls = 0; wrc = 0; done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); #1;
      if (!c_waitrequest) begin done = 1'b1; break; end
      stalls++;
      @(posedge clk); #1;
    end
    chk("wr_accept", 32'(done), 32'd1);
    if (done) begin
      e.a = a[31:2]; e.d = d; e.be = be;
      exp_q.push_back(e);
      wrc = bus_wr_cnt;
      @(posedge clk); #1;
    end
    c_write = 1'b0; c_address = '0; c_writedata = '0; c_byteenable = '0;
  endtask

  // Upstream read; checks the returned word against the golden memory
  task automatic up_read(input logic [31:0] a, output int stalls, output logic [31:0] data);
    bit done;
    c_read = 1'b1; c_address = a;
    stalls = 0; data = '0; done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); #1;
      if (!c_waitrequest) begin done = 1'b1; break; end
      stalls++;
      @(posedge clk); #1;
    end
    chk("rd_complete", 32'(done), 32'd1);
    if (done) begin
      data = c_readdata;
      chk("rd_data", data, golden_read(a));
      @(posedge clk); #1;
    end
    c_read = 1'b0; c_address = '0;
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (empty) begin ok = 1'b1; break; end
    end
    chk("drain_empty", 32'(ok), 32'd1);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          st, wrc, b;
    logic [31:0] d;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_byteenable", 32'(byteenable), 32'd0);
    chk("rst_readdata", c_readdata, 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single write, zero-wait accept, background drain
    wr_mode = 0;
    up_write(32'h100, 32'h11, 4'hF, st, wrc);
    chk("t1_accept_stalls", 32'(st), 32'd0);
    chk("t1_c1_empty", 32'(empty), 32'd0);
    @(posedge clk); #1;
    chk("t1_c2_write", 32'(write), 32'd1);
    chk("t1_c2_addr", address, 32'h100);
    chk("t1_c2_data", writedata, 32'h11);
    @(posedge clk); #1;
    chk("t1_c3_empty", 32'(empty), 32'd1);
    up_read(32'h100, st, d);
    chk("t1_miss_stalls", 32'(st), 32'd2);
    chk("t1_miss_data", d, 32'h11);

    // Fill while memory stalls; fifth write waits for the first pop
    wr_mode = 1;
    b = bus_wr_cnt;
    for (int i = 0; i < 4; i++) begin
      up_write(32'h500 + 32'(4 * i), 32'hA000 + 32'(i), 4'hF, st, wrc);
      chk("t2_fill_stalls", 32'(st), 32'd0);
    end
    fork
      up_write(32'h510, 32'hA004, 4'hF, st, wrc);
      begin repeat (6) @(posedge clk); #1; wr_mode = 0; end
    join
    chk("t2_w5_stalled", 32'(st != 0), 32'd1);
    chk("t2_w5_after_pop", 32'(wrc - b), 32'd1);
    wait_empty();

    // Full-word hit is forwarded without a bus read
    b = bus_rd_cnt;
    up_write(32'h200, 32'hAA, 4'hF, st, wrc);
    up_read(32'h200, st, d);
    chk("t3_fwd_stalls", 32'(st), 32'd1);
    chk("t3_fwd_data", d, 32'hAA);
    chk("t3_no_bus_read", 32'(bus_rd_cnt - b), 32'd0);
    wait_empty();

    // Partial-word hit drains first, then reads memory
    b = bus_wr_cnt;
    up_write(32'h300, 32'h1234_5678, 4'h3, st, wrc);
    up_read(32'h300, st, d);
    chk("t4_data", d, 32'h5A5A_5678);
    chk("t4_pending_at_read", 32'(rd_pending), 32'd0);
    chk("t4_wr_before_rd", 32'(bus_wr_cnt - b), 32'd1);
    wait_empty();

    // Miss read overtakes queued writes
    up_write(32'h400, 32'h44, 4'hF, st, wrc);
    up_write(32'h404, 32'h45, 4'hF, st, wrc);
    up_read(32'h800, st, d);
    chk("t5_data", d, 32'h5A5A_0200);
    chk("t5_pending_at_read", 32'(rd_pending), 32'd1);
    wait_empty();

    // Reset in the middle of a stalled bus write
    wr_mode = 1;
    for (int i = 0; i < 3; i++) up_write(32'h600 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF, st, wrc);
    chk("t6_write_active", 32'(write), 32'd1);
    #3 reset = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_write", 32'(write), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_address", address, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    wr_mode = 0;
    b = bus_wr_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_bus_writes", 32'(bus_wr_cnt - b), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    up_read(32'h600, st, d);
    chk("t6_discarded", d, 32'h5A5A_0180);

    // Randomised traffic over a small address window to provoke hazards
    wr_mode = 2;
    for (int n = 0; n < 120; n++) begin
      int          r;
      logic [31:0] a;
      logic [3:0]  be;
      r  = int'($urandom_range(0, 9));
      a  = 32'h1000 + 32'(4 * $urandom_range(0, 5));
      be = (r < 3) ? 4'hF : 4'($urandom_range(1, 15));
      if (r < 6) up_write(a, $urandom, be, st, wrc);
      else       up_read(a, st, d);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
